// File: rtl/core_seq_pkg.sv
// Shared definitions for the core sequencer: state encoding and default widths.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } seq_state_e;

  localparam int LD_CNT_W_DEF = 8;
  localparam int CYC_W_DEF    = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value; synchronous clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/core_sequencer.sv
// Sequencer for a small core: loads instruction memory, then runs, single-steps
// or halts the datapath, with a PC breakpoint and a saturating cycle counter.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int LD_CNT_W = LD_CNT_W_DEF,
  parameter int CYC_W    = CYC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_load,
  input  logic                cmd_run,
  input  logic                cmd_step,
  input  logic                cmd_halt,
  input  logic                ld_valid,
  input  logic [31:0]         ld_data,
  input  logic [LD_CNT_W-1:0] ld_count,
  output logic                ld_ready,
  output logic                imem_we,
  output logic [31:0]         imem_addr,
  output logic [31:0]         imem_wd,
  output logic                core_rst,
  output logic                core_en,
  input  logic [31:0]         pc,
  input  logic [31:0]         brk_addr,
  input  logic                brk_en,
  output logic [2:0]          state,
  output logic [CYC_W-1:0]    cycles
);

  seq_state_e          state_q, state_d;
  logic [LD_CNT_W-1:0] idx_q, idx_d;
  logic [LD_CNT_W-1:0] cnt_q, cnt_d;
  logic                mask_q, mask_d;
  logic                cyc_clr, cyc_inc;
  logic                brk_hit;
  logic [31:0]         idx_ext;

  // The mask lets the first cycle after a resume execute the breakpoint address.
  assign brk_hit = brk_en && (pc == brk_addr) && !mask_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mask_d   = 1'b0;
    ld_ready = 1'b0;
    imem_we  = 1'b0;
    core_en  = 1'b0;
    cyc_clr  = 1'b0;
    cyc_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_load) begin
          state_d = S_LOAD;
          cnt_d   = ld_count;
          idx_d   = '0;
        end else if (cmd_run) begin
          state_d = S_RUN;
          cyc_clr = 1'b1;
        end else if (cmd_step) begin
          state_d = S_STEP;
          cyc_clr = 1'b1;
        end
      end
      S_LOAD: begin
        ld_ready = (cnt_q != '0) && !cmd_halt;
        imem_we  = ld_ready && ld_valid;
        if (cmd_halt || (cnt_q == '0)) begin
          state_d = S_IDLE;
        end else if (imem_we) begin
          if (idx_q == cnt_q - LD_CNT_W'(1)) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + LD_CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        if (brk_hit) begin
          state_d = S_HALT;
        end else begin
          core_en = 1'b1;
          cyc_inc = 1'b1;
          if (cmd_halt) begin
            state_d = S_HALT;
          end
        end
      end
      S_STEP: begin
        core_en = 1'b1;
        cyc_inc = 1'b1;
        state_d = S_HALT;
      end
      S_HALT: begin
        if (cmd_load) begin
          state_d = S_LOAD;
          cnt_d   = ld_count;
          idx_d   = '0;
        end else if (cmd_run) begin
          state_d = S_RUN;
          mask_d  = 1'b1;
        end else if (cmd_step) begin
          state_d = S_STEP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  sat_counter #(.WIDTH(CYC_W)) u_cycles (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cyc_clr),
    .inc   (cyc_inc),
    .count (cycles)
  );

  assign idx_ext   = 32'(idx_q);
  assign imem_addr = {idx_ext[29:0], 2'b00};
  assign imem_wd   = ld_data;
  assign core_rst  = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_HALT);
  assign state     = state_q;

endmodule
